rr_mux_n_reg: RTL and testbench
===============================

// Module: rr_mux_n_reg
// PURPOSE
//   Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready
//   handshakes and built-in arbitration (round-robin or fixed priority).
//   Generalises the combinational 4:1 bit-sliced muxes to any channel count and
//   width, adding one output pipeline register and backpressure.
//   Sits between multiple producers (e.g. register-file or ALU result sources)
//   and a single consumer stage.
// PARAMETERS
//   WIDTH   16  data bits per channel
//   N       4   number of input channels (>=2, need not be a power of 2)
//   MODE    0   0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
//   CHAN_W  localparam = max(1, clog2(N)); width of channel index
// PORTS
//   clk        in   1          clock; all state updates on rising edge
//   rst        in   1          synchronous reset, active-high
//   in_data    in   N*WIDTH    channel i data at [i*WIDTH +: WIDTH]
//   in_valid   in   N          channel i has data
//   in_ready   out  N          channel i granted this cycle (combinational)
//   out_data   out  WIDTH      registered selected data
//   out_chan   out  CHAN_W     registered index of channel that supplied out_data
//   out_valid  out  1          out_data/out_chan valid
//   out_ready  in   1          consumer accepts output this cycle
// BEHAVIOUR
//   - Reset (rst=1 at edge): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
//     Any in-flight output word is discarded; in_ready is all-zero while rst=1.
//   - load = !out_valid | out_ready (output register free or draining this cycle).
//   - Grant: when load=1 and |in_valid, exactly one channel g is granted;
//     in_ready = one-hot(g). Otherwise in_ready = 0. in_ready never has >1 bit set.
//   - Transfer on channel i when in_valid[i] & in_ready[i]; at that edge:
//     out_data <= in_data[g], out_chan <= g, out_valid <= 1. Latency: 1 cycle.
//   - load=1 and no in_valid: out_valid <= 0 (data/chan may hold old values).
//   - load=0 (out_valid=1, out_ready=0): out_data, out_chan, out_valid held stable.
//   - Throughput: one word per cycle when out_ready held high.
//   - MODE 0: search starts at rr_ptr, ascending, wraps N-1 -> 0; first valid
//     channel wins. On transfer rr_ptr <= (g==N-1) ? 0 : g+1. rr_ptr unchanged
//     when no transfer. Every persistently valid channel granted within N transfers.
//   - MODE 1: lowest-index valid channel wins; rr_ptr unused (stays 0).
//   - in_valid may deassert without a grant; no data from ungranted channels
//     is captured. in_data of non-granted channels is don't-care.
//   - Simultaneous out_ready and new grant: old word consumed and new word
//     loaded at the same edge (no bubble).
//   - Non-power-of-2 N: pointer wraps at N-1; indices >= N never granted.
// TESTING
//   1. Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0,
//      out_data=0, out_chan=0.
//   2. RR fairness (N=4, MODE 0, out_ready=1, in_valid=4'b1111, data=ch index*0x1111)
//      -> out_chan sequence 0,1,2,3,0 on consecutive cycles; out_data 0x0000,0x1111,...
//   3. Backpressure: out_valid=1, out_chan=2, out_ready=0 for 5 cycles with
//      in_valid=4'b1011 -> in_ready=0, out_data/out_chan stable; on out_ready=1
//      next grant is channel 3, then 0.
//   4. Fixed priority (MODE 1): in_valid=4'b1100 then 4'b1110 -> grants 2 then 1;
//      channel 3 starved while lower channels valid.
//   5. Wrap with N=3, WIDTH=8: rr_ptr=2, in_valid=3'b011 -> grant 0, rr_ptr->1;
//      confirm out_chan never exceeds 2.
//   6. Reset mid-stream: rst pulsed while out_valid=1, out_ready=0 -> word dropped,
//      out_valid=0 next cycle, first grant after reset is channel 0.

Source files
------------

// File: rtl/rr_mux_n_reg.sv
// rr_mux_n_reg: N-channel registered mux with valid/ready handshakes and round-robin or fixed-priority arbitration
module rr_mux_n_reg #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  parameter int MODE = 0,
  localparam int CHAN_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CHAN_W-1:0]    out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [WIDTH-1:0]  w_ch [N];
  logic [WIDTH-1:0]  r_data;
  logic [CHAN_W-1:0] r_chan, r_ptr, w_base, w_idx, w_gnt, w_ptr_nxt;
  logic              r_valid, w_any, w_load, w_fire;
  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
  end
  assign w_load = !r_valid || out_ready;
  assign w_base = (MODE != 0) ? '0 : r_ptr;
  // search from w_base upward, wrapping at N-1 so indices >= N are never visited
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(w_base) + k >= N) ? CHAN_W'(int'(w_base) + k - N) : CHAN_W'(int'(w_base) + k);
      if (!w_any && in_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  assign w_fire    = w_load && w_any && !rst;
  assign in_ready  = w_fire ? ({{(N-1){1'b0}}, 1'b1} << w_gnt) : '0;
  assign w_ptr_nxt = (w_gnt == CHAN_W'(N-1)) ? '0 : w_gnt + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= w_ch[w_gnt];
        r_chan <= w_gnt;
        r_ptr  <= (MODE != 0) ? '0 : w_ptr_nxt;
      end
    end
  end
  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_rr_mux_n_reg.sv
// tb_rr_mux_n_reg: scoreboard bench driving RR N=4, fixed-priority N=4 and RR N=3/WIDTH=8 instances
module tb_rr_mux_n_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din  [3];
  logic [3:0]  vin  [3];
  logic        ordy [3];
  logic [3:0]  r0, r1;
  logic [2:0]  r2;
  logic [15:0] od0, od1;
  logic [7:0]  od2;
  logic [1:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;
  logic [3:0]  rv [3];
  logic [15:0] dv [3];
  logic [1:0]  cv [3];
  logic        vv [3];
  int nn [3] = '{4, 4, 3};
  int md [3] = '{0, 1, 0};
  int ww [3] = '{16, 16, 8};
  int ptr [3];
  bit full [3];
  int q0 [$], q1 [$], q2 [$];
  int vectors = 0, miscompares = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  rr_mux_n_reg #(.WIDTH(16), .N(4), .MODE(0)) u0 (.clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]),
    .in_ready(r0), .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(ordy[0]));
  rr_mux_n_reg #(.WIDTH(16), .N(4), .MODE(1)) u1 (.clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]),
    .in_ready(r1), .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(ordy[1]));
  rr_mux_n_reg #(.WIDTH(8), .N(3), .MODE(0)) u2 (.clk(clk), .rst(rst), .in_data(din[2][23:0]), .in_valid(vin[2][2:0]),
    .in_ready(r2), .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(ordy[2]));

  always_comb begin
    rv[0] = r0;  rv[1] = r1;  rv[2] = {1'b0, r2};
    dv[0] = od0; dv[1] = od1; dv[2] = {8'h00, od2};
    cv[0] = oc0; cv[1] = oc1; cv[2] = oc2;
    vv[0] = ov0; vv[1] = ov1; vv[2] = ov2;
  end

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic qpush(int d, int x);
    case (d)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic qpop(int d);
    case (d)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qclear(int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  function automatic int qfront(int d);
    return (d == 0) ? q0[0] : (d == 1) ? q1[0] : q2[0];
  endfunction

  // reference arbitration: first valid channel in circular order from the start point
  function automatic int pick(int n, int mode, int p, logic [3:0] v);
    int base = (mode != 0) ? 0 : p;
    for (int k = 0; k < n; k++)
      if (v[(base + k) % n]) return (base + k) % n;
    return -1;
  endfunction

  // one clock of stimulus: check expected grants, then account the transfer in the model
  task automatic cycle();
    int g [3];
    bit ld [3];
    logic [63:0] t;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      ld[d] = !full[d] || ordy[d];
      g[d] = (rst || !ld[d]) ? -1 : pick(nn[d], md[d], ptr[d], vin[d]);
      chk("in_ready", d, {28'b0, rv[d]}, (g[d] < 0) ? 32'd0 : (32'd1 << g[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        qclear(d);
        full[d] = 1'b0;
        ptr[d] = 0;
      end else begin
        if (g[d] >= 0) begin
          t = din[d] >> (g[d] * ww[d]);
          qpush(d, g[d] * 65536 + (int'(t[15:0]) & ((1 << ww[d]) - 1)));
          ptr[d] = (md[d] != 0) ? 0 : (g[d] + 1) % nn[d];
        end
        full[d] = (g[d] >= 0) ? 1'b1 : (ld[d] ? 1'b0 : full[d]);
      end
    end
    #1;
  endtask

  task automatic set_all(logic [3:0] v, logic r);
    for (int d = 0; d < 3; d++) begin
      vin[d] = v;
      ordy[d] = r;
      din[d] = '0;
      for (int c = 0; c < nn[d]; c++)
        din[d] = din[d] | (64'(c * ((ww[d] == 16) ? 'h1111 : 'h11)) << (c * ww[d]));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        chk("out_valid", d, {31'b0, vv[d]}, {31'b0, qsize(d) != 0});
        if (vv[d] && qsize(d) > 0) begin
          chk("out_chan", d, {30'b0, cv[d]}, qfront(d) >> 16);
          chk("out_data", d, {16'b0, dv[d]}, qfront(d) & 'hffff);
          if (ordy[d] && !rst) qpop(d);
        end
      end
    end
  end

  initial begin
    set_all(4'b1111, 1'b1);
    rst = 1'b1;
    cycle();
    started = 1'b1;
    cycle();
    for (int d = 0; d < 3; d++) begin
      chk("rst_data", d, {16'b0, dv[d]}, 32'd0);
      chk("rst_chan", d, {30'b0, cv[d]}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("rr_seq", 0, {30'b0, oc0}, i % 4);
      chk("rr_data", 0, {16'b0, od0}, (i % 4) * 'h1111);
    end
    set_all(4'b1011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_chan", 0, {30'b0, oc0}, 32'd2);
      chk("bp_data", 0, {16'b0, od0}, 32'h2222);
    end
    set_all(4'b1011, 1'b1);
    cycle();
    chk("bp_next", 0, {30'b0, oc0}, 32'd3);
    cycle();
    chk("bp_wrap", 0, {30'b0, oc0}, 32'd0);
    set_all(4'b1100, 1'b1);
    cycle();
    chk("prio_a", 1, {30'b0, oc1}, 32'd2);
    set_all(4'b1110, 1'b1);
    cycle();
    chk("prio_b", 1, {30'b0, oc1}, 32'd1);
    cycle();
    chk("prio_c", 1, {30'b0, oc1}, 32'd1);
    set_all(4'b1111, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_v", 0, {31'b0, ov0}, 32'd0);
    rst = 1'b0;
    set_all(4'b1111, 1'b1);
    cycle();
    chk("post_rst0", 0, {30'b0, oc0}, 32'd0);
    chk("post_rst2", 2, {30'b0, oc2}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 3; d++) begin
        vin[d] = 4'($urandom_range(0, 15));
        din[d] = {$urandom, $urandom};
        ordy[d] = ($urandom_range(0, 9) < 7);
      end
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
